// File: rtl/sys_defs.sv
// Shared bus/memory definitions for the processor-to-memory interface.
package sys_defs;

    localparam int XLEN         = 32;
    localparam int MEM_TAG_BITS = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // One in-flight load: read value and tag captured at acceptance,
    // plus the cycles remaining before it may complete.
    typedef struct packed {
        logic                    vld;
        logic [MEM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
        logic [3:0]              cnt;
    } load_slot_t;

    // Tags run 1..15 and wrap back to 1; 0 is reserved for "nothing".
    function automatic logic [MEM_TAG_BITS-1:0] next_tag(input logic [MEM_TAG_BITS-1:0] t);
        return (t == '1) ? MEM_TAG_BITS'(1) : t + MEM_TAG_BITS'(1);
    endfunction

endpackage

// File: rtl/mem_load_queue.sv
// Circular FIFO of in-flight loads, each with a latency countdown.
// Only the head may complete; completion is shown from registers and the
// slot is popped on the following edge.
module mem_load_queue
    import sys_defs::*;
#(
    parameter int DEPTH   = 3,
    parameter int LATENCY = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [MEM_TAG_BITS-1:0] push_tag,
    input  logic [63:0]             push_data,
    output logic                    can_push,
    output logic [MEM_TAG_BITS-1:0] done_tag,
    output logic [63:0]             done_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    load_slot_t       slots [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A completing head frees its slot in time for a same-cycle push.
    always_comb begin
        pop       = slots[head].vld && (slots[head].cnt == 4'd0);
        can_push  = (count < CNT_W'(DEPTH)) || pop;
        do_push   = push && can_push;
        done_tag  = '0;
        done_data = '0;
        if (reset && pop) begin
            done_tag  = slots[head].tag;
            done_data = slots[head].data;
        end
    end

    // Countdown, pop and push; a push into the slot just popped wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (slots[i].vld && slots[i].cnt != 4'd0)
                    slots[i].cnt <= slots[i].cnt - 4'd1;
            if (pop) begin
                slots[head].vld <= 1'b0;
                head            <= wrap_inc(head);
            end
            if (do_push) begin
                slots[tail] <= '{vld: 1'b1, tag: push_tag, data: push_data,
                                 cnt: 4'(LATENCY - 1)};
                tail        <= wrap_inc(tail);
            end
            if (do_push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory model: tag allocation, backing store, and a
// bounded queue of outstanding loads returning in order.
module mem_responder
    import sys_defs::*;
#(
    parameter int MEM_LATENCY     = 4,
    parameter int MAX_OUTSTANDING = 3,
    parameter int MEM_WORDS       = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  BUS_COMMAND              proc2mem_command,
    input  logic [XLEN-1:0]         proc2mem_addr,
    input  logic [63:0]             proc2mem_data,
    output logic [MEM_TAG_BITS-1:0] mem2proc_response,
    output logic [63:0]             mem2proc_data,
    output logic [MEM_TAG_BITS-1:0] mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [63:0]             mem [MEM_WORDS];
    logic [IDX_W-1:0]        idx;
    logic [MEM_TAG_BITS-1:0] tag;
    logic                    is_load;
    logic                    is_store;
    logic                    can_push;
    logic                    accept;
    logic                    unused_addr_bits;

    assign idx              = proc2mem_addr[3 +: IDX_W];
    assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:3+IDX_W]};

    // Stores always go through; loads need a slot (possibly one freed this cycle).
    always_comb begin
        is_load           = reset && (proc2mem_command == BUS_LOAD);
        is_store          = reset && (proc2mem_command == BUS_STORE);
        accept            = is_store || (is_load && can_push);
        mem2proc_response = accept ? tag : '0;
    end

    // Tag counter advances only on an accepted command.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      tag <= MEM_TAG_BITS'(1);
        else if (accept) tag <= next_tag(tag);
    end

    // Backing store is not reset; it keeps contents across resets.
    always_ff @(posedge clock) begin
        if (is_store) mem[idx] <= proc2mem_data;
    end

    // Loads sample the array at acceptance, so later stores cannot affect them.
    mem_load_queue #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (MEM_LATENCY)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (is_load),
        .push_tag  (tag),
        .push_data (mem[idx]),
        .can_push  (can_push),
        .done_tag  (mem2proc_tag),
        .done_data (mem2proc_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at default parameters.
module tb_mem_responder;
    import sys_defs::*;

    logic        clock = 1'b0;
    logic        reset;
    BUS_COMMAND  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  response;
    logic [63:0] rdata;
    logic [3:0]  rtag;

    int vectors = 0;
    int errors  = 0;

    localparam logic [63:0] D_SCN1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D_NEW  = 64'h0BAD_F00D_0000_0002;
    localparam logic [63:0] D0     = 64'h1111_0000_0000_0020;
    localparam logic [63:0] D1     = 64'h2222_0000_0000_0028;
    localparam logic [63:0] D2     = 64'h3333_0000_0000_0030;
    localparam logic [63:0] D3     = 64'h4444_0000_0000_0038;

    always #5 clock = ~clock;

    mem_responder dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (response),
        .mem2proc_data     (rdata),
        .mem2proc_tag      (rtag)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply a command and let combinational outputs settle (still mid-cycle).
    task automatic drive(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d);
        cmd   = c;
        addr  = a;
        wdata = d;
        #1;
    endtask

    task automatic chk_done(input string name, input logic [3:0] t, input logic [63:0] d);
        chk({name, "_tag"}, 64'(rtag), 64'(t));
        chk({name, "_data"}, rdata, d);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(BUS_STORE, 32'h40, 64'h55);
        chk("rst_resp", 64'(response), 64'd0);
        chk_done("rst_out", 4'd0, 64'd0);
        tick();
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        cmd   = BUS_NONE;
        addr  = '0;
        wdata = '0;
        #2;
        do_reset();

        // Scenario 1: store then load same word.
        drive(BUS_STORE, 32'h10, D_SCN1);
        chk("s1_store_resp", 64'(response), 64'd1);
        tick();
        drive(BUS_LOAD, 32'h10, 64'h0);
        chk("s1_load_resp", 64'(response), 64'd2);
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        for (int k = 0; k < 3; k++) begin
            chk_done("s1_wait", 4'd0, 64'd0);
            tick();
        end
        chk_done("s1_done", 4'd2, D_SCN1);
        tick();
        chk_done("s1_after", 4'd0, 64'd0);

        // Low address bits ignored; a later store does not disturb the load.
        drive(BUS_LOAD, 32'h17, 64'h0);
        chk("s1b_load_resp", 64'(response), 64'd3);
        tick();
        drive(BUS_STORE, 32'h10, D_NEW);
        chk("s1b_store_resp", 64'(response), 64'd4);
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        tick();
        tick();
        chk_done("s1b_done", 4'd3, D_SCN1);
        tick();
        drive(BUS_LOAD, 32'h10, 64'h0);
        chk("s1c_load_resp", 64'(response), 64'd5);
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        tick();
        tick();
        tick();
        chk_done("s1c_done", 4'd5, D_NEW);
        tick();

        // Preload words for scenario 2; storage survives the following reset.
        drive(BUS_STORE, 32'h20, D0); chk("pre0", 64'(response), 64'd6); tick();
        drive(BUS_STORE, 32'h28, D1); chk("pre1", 64'(response), 64'd7); tick();
        drive(BUS_STORE, 32'h30, D2); chk("pre2", 64'(response), 64'd8); tick();
        drive(BUS_STORE, 32'h38, D3); chk("pre3", 64'(response), 64'd9); tick();
        do_reset();

        // Scenario 2: fill the queue; the 4th load is rejected.
        drive(BUS_LOAD, 32'h20, 64'h0); chk("s2_r1", 64'(response), 64'd1); tick();
        drive(BUS_LOAD, 32'h28, 64'h0); chk("s2_r2", 64'(response), 64'd2); tick();
        drive(BUS_LOAD, 32'h30, 64'h0); chk("s2_r3", 64'(response), 64'd3); tick();
        drive(BUS_LOAD, 32'h38, 64'h0);
        chk("s2_full_resp", 64'(response), 64'd0);
        chk_done("s2_nodone", 4'd0, 64'd0);
        tick();
        // Scenario 3: retry while tag 1 pops -> accepted as tag 4.
        drive(BUS_LOAD, 32'h38, 64'h0);
        chk("s3_pop_push_resp", 64'(response), 64'd4);
        chk_done("s2_c1", 4'd1, D0);
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        chk_done("s2_c2", 4'd2, D1);
        tick();
        chk_done("s2_c3", 4'd3, D2);
        tick();
        chk_done("s3_gap", 4'd0, 64'd0);
        tick();
        chk_done("s3_c4", 4'd4, D3);
        tick();
        chk_done("s3_after", 4'd0, 64'd0);

        // Scenario 4: 16 stores wrap the tag counter, no completions.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(BUS_STORE, 32'h100 + 32'(i * 8), 64'(i));
            chk("s4_resp", 64'(response), 64'((i % 15) + 1));
            chk("s4_notag", 64'(rtag), 64'd0);
            tick();
        end
        drive(BUS_NONE, 32'h0, 64'h0);
        chk("s4_notag_end", 64'(rtag), 64'd0);

        // Scenario 5: reset with loads in flight.
        do_reset();
        drive(BUS_LOAD, 32'h20, 64'h0); chk("s5_r1", 64'(response), 64'd1); tick();
        drive(BUS_LOAD, 32'h28, 64'h0); chk("s5_r2", 64'(response), 64'd2); tick();
        drive(BUS_LOAD, 32'h30, 64'h0);
        chk("s5_r3_pre", 64'(response), 64'd3);
        reset = 1'b0;
        #1;
        chk("s5_async_resp", 64'(response), 64'd0);
        chk_done("s5_async_out", 4'd0, 64'd0);
        tick();
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk_done("s5_flushed", 4'd0, 64'd0);
            tick();
        end
        drive(BUS_LOAD, 32'h30, 64'h0);
        chk("s5_first_tag", 64'(response), 64'd1);
        tick();
        drive(BUS_NONE, 32'h0, 64'h0);
        tick();
        tick();
        tick();
        chk_done("s5_done", 4'd1, D2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 4, cycles from load acceptance edge to data return; legal range 1..15.
REQ-002 Parameter MAX_OUTSTANDING, default 3, load-queue depth; legal range 1..8.
REQ-003 Parameter MEM_WORDS, default 1024, 64-bit words of backing storage.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when low.
REQ-006 proc2mem_command  input  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE request from the LSQ.
REQ-007 proc2mem_addr  input  `XLEN  byte address; word index = addr[3 +: log2(MEM_WORDS)], addr[2:0] ignored.
REQ-008 proc2mem_data  input  64  store data.
REQ-009 mem2proc_response  output  4  tag granted to this cycle's command; 0 = rejected or no command.
REQ-010 mem2proc_data  output  64  load return data.
REQ-011 mem2proc_tag  output  4  tag of the load completing this cycle; 0 = no completion.

Function
REQ-012 A command is accepted when it is BUS_LOAD or BUS_STORE, reset is high, and (for loads) a queue slot is free.
REQ-013 A slot whose load completes in the current cycle counts as free for an acceptance in that same cycle.
REQ-014 Stores never occupy a slot and are always accepted while out of reset.
REQ-015 mem2proc_response is combinational, valid in the same cycle as the command: the next tag if accepted, else 0.
REQ-016 The tag counter cycles 1,2,...,15,1,...; it never produces 0 and advances by one only on an accepted command.
REQ-017 On an accepted store, the addressed word is written with proc2mem_data at that edge.
REQ-018 On an accepted load, the addressed word is read at the acceptance edge, and the read value and tag are captured into the tail slot.
REQ-019 A load is therefore unaffected by stores accepted after it; a store accepted in an earlier cycle is visible to it.
REQ-020 Each slot carries a countdown initialised to MEM_LATENCY-1 and decremented every cycle.
REQ-021 In the cycle when the head slot's countdown reaches 0, mem2proc_tag/mem2proc_data present its tag/data from registers, and the slot is popped at the next edge.
REQ-022 Completions are in acceptance order, at most one per cycle; a load accepted at edge E completes in the cycle after edge E+MEM_LATENCY-1.
REQ-023 When no completion is pending, mem2proc_tag = 0 and mem2proc_data = 0.
REQ-024 Queue head/tail pointers wrap modulo MAX_OUTSTANDING; the full/empty distinction uses an occupancy count (0..MAX_OUTSTANDING).
REQ-025 Simultaneous pop and push keep the count unchanged; push at full without a pop is rejected (response 0).

Reset
REQ-026 While reset is low: slots invalidated, count 0, tag counter returns to 1, mem2proc_tag = 0, mem2proc_data = 0, mem2proc_response = 0.
REQ-027 A reset mid-operation discards all in-flight loads, which never complete.
REQ-028 Storage contents are not reset; they are preloaded via testbench backdoor.

Structure
REQ-029 BUS_COMMAND, `XLEN, and a new MEM_TAG_BITS (=4) constant live in the shared sys_defs package.
REQ-030 One sub-module is natural: mem_load_queue (the circular slot FIFO with countdowns); storage and tag logic stay in mem_responder.

Verification
REQ-031 Scenario 1: reset, then BUS_STORE addr 0x10 data 0xDEAD_BEEF_0000_0001 -> response 1 same cycle; next cycle BUS_LOAD 0x10 -> response 2; 4 cycles later tag 2, data 0xDEAD_BEEF_0000_0001.
REQ-032 Scenario 2: BUS_LOAD at addr 0x20, 0x28, 0x30, 0x38 on consecutive cycles (defaults) -> tags 1,2,3 granted; the 4th gets response 0; completions in cycles 4,5,6 with tags 1,2,3.
REQ-033 Scenario 3: keep a load issued every cycle while the head completes -> the 4th issue coincides with the pop of tag 1 and is accepted with tag 4.
REQ-034 Scenario 4: 16 accepted stores -> responses 1..15 then 1; no mem2proc_tag activity.
REQ-035 Scenario 5: issue 2 loads, pull reset low one cycle later -> outputs 0 asynchronously; no completion afterwards; the first command after release gets tag 1.
